// File: rtl/sub_max_stage.sv
// sub_max_stage
//   Second half of the softmax front end: subtracts the row maximum from every
//   lane so that all results are <= 0, ready for the exponent approximation.
//   Two-stage pipeline: stage 1 registers the lanes with their selected max,
//   stage 2 registers the clamped differences. i_en low freezes all pipeline
//   state; the statistics clear acts regardless of i_en.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-low reset
//   i_en                    pipeline enable (0 = stall)
//   i_valid_max             input beat valid
//   i_length_mode           row segmentation (0:16, 1:32, 2:64, 3:multi-beat, 4-15 reserved)
//   i_in_flat               64 x 16b signed lanes, lane k at [16k+15:16k]
//   i_lane_mask             1 = lane carries real data
//   i_global_max            multi-beat row max
//   i_max64_0 / i_max32_* / i_max16_*  segment maxima from the max stage
//   i_clr_stats             synchronous clear of o_sat_cnt / o_mode_err
//   o_valid                 output beat valid
//   o_diff_flat             per-lane x - max, same packing as i_in_flat
//   o_lane_mask             mask aligned with o_diff_flat
//   o_length_mode_byp       mode aligned with o_diff_flat
//   o_sat_cnt               saturating count of saturated/clamped unmasked lanes
//   o_mode_err              sticky flag: reserved mode accepted on a valid beat
module sub_max_stage #(
  parameter int DATA_W   = 16,
  parameter int LANES    = 64,
  parameter int SATCNT_W = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic                    i_valid_max,
  input  logic [3:0]              i_length_mode,
  input  logic [LANES*DATA_W-1:0] i_in_flat,
  input  logic [LANES-1:0]        i_lane_mask,
  input  logic [DATA_W-1:0]       i_global_max,
  input  logic [DATA_W-1:0]       i_max64_0,
  input  logic [DATA_W-1:0]       i_max32_0,
  input  logic [DATA_W-1:0]       i_max32_1,
  input  logic [DATA_W-1:0]       i_max16_0,
  input  logic [DATA_W-1:0]       i_max16_1,
  input  logic [DATA_W-1:0]       i_max16_2,
  input  logic [DATA_W-1:0]       i_max16_3,
  input  logic                    i_clr_stats,
  output logic                    o_valid,
  output logic [LANES*DATA_W-1:0] o_diff_flat,
  output logic [LANES-1:0]        o_lane_mask,
  output logic [3:0]              o_length_mode_byp,
  output logic [SATCNT_W-1:0]     o_sat_cnt,
  output logic                    o_mode_err
);

  localparam int CNT_W = $clog2(LANES + 1);
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic [3:0][DATA_W-1:0] max16_w;
  logic [1:0][DATA_W-1:0] max32_w;

  assign max16_w = {i_max16_3, i_max16_2, i_max16_1, i_max16_0};
  assign max32_w = {i_max32_1, i_max32_0};

  // Per-lane max selection; reserved modes fall back to the global max.
  logic [LANES-1:0][DATA_W-1:0] sel_max_d;

  always_comb begin
    sel_max_d = '0;
    for (int k = 0; k < LANES; k++) begin
      case (i_length_mode)
        4'd0:    sel_max_d[k] = max16_w[k[5:4]];
        4'd1:    sel_max_d[k] = max32_w[k[5]];
        4'd2:    sel_max_d[k] = i_max64_0;
        default: sel_max_d[k] = i_global_max;
      endcase
    end
  end

  // Stage 1
  logic [LANES-1:0][DATA_W-1:0] in_q;
  logic [LANES-1:0][DATA_W-1:0] max_q;
  logic [LANES-1:0]             mask_q;
  logic [3:0]                   mode_q;
  logic                         vld_q;

  // Stage 2
  logic [LANES-1:0][DATA_W-1:0] diff_q;
  logic [LANES-1:0]             mask2_q;
  logic [3:0]                   mode2_q;
  logic                         vld2_q;

  logic [SATCNT_W-1:0]          sat_cnt_q;
  logic                         mode_err_q;

  // Difference in DATA_W+1 bits: the top two bits tell underflow (10) and
  // a strictly positive result (0x with non-zero magnitude) apart.
  logic [LANES-1:0][DATA_W-1:0] diff_d;
  logic [CNT_W-1:0]             sat_lanes_d;
  logic [DATA_W:0]              sub;

  always_comb begin
    diff_d      = '0;
    sat_lanes_d = '0;
    sub         = '0;
    for (int k = 0; k < LANES; k++) begin
      sub = {in_q[k][DATA_W-1], in_q[k]} - {max_q[k][DATA_W-1], max_q[k]};
      if (!mask_q[k]) begin
        diff_d[k] = MOST_NEG;
      end else if (sub[DATA_W] && !sub[DATA_W-1]) begin
        diff_d[k]   = MOST_NEG;
        sat_lanes_d = sat_lanes_d + CNT_W'(1);
      end else if (!sub[DATA_W] && (sub[DATA_W-1:0] != '0)) begin
        diff_d[k]   = '0;
        sat_lanes_d = sat_lanes_d + CNT_W'(1);
      end else begin
        diff_d[k] = sub[DATA_W-1:0];
      end
    end
  end

  // Saturating accumulate; the extra carry bit flags overflow.
  logic [SATCNT_W:0]   sat_sum;
  logic [SATCNT_W-1:0] sat_cnt_d;
  logic                mode_err_set;

  assign sat_sum      = {1'b0, sat_cnt_q} + (SATCNT_W+1)'(sat_lanes_d);
  assign sat_cnt_d    = sat_sum[SATCNT_W] ? '1 : sat_sum[SATCNT_W-1:0];
  assign mode_err_set = i_en & i_valid_max & (i_length_mode > 4'd3);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      in_q    <= '0;
      max_q   <= '0;
      mask_q  <= '0;
      mode_q  <= '0;
      vld_q   <= 1'b0;
      diff_q  <= '0;
      mask2_q <= '0;
      mode2_q <= '0;
      vld2_q  <= 1'b0;
    end else if (i_en) begin
      in_q    <= i_in_flat;
      max_q   <= sel_max_d;
      mask_q  <= i_lane_mask;
      mode_q  <= i_length_mode;
      vld_q   <= i_valid_max;
      diff_q  <= diff_d;
      mask2_q <= mask_q;
      mode2_q <= mode_q;
      vld2_q  <= vld_q;
    end
  end

  // Statistics: clear wins over any event in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sat_cnt_q  <= '0;
      mode_err_q <= 1'b0;
    end else if (i_clr_stats) begin
      sat_cnt_q  <= '0;
      mode_err_q <= 1'b0;
    end else begin
      if (i_en && vld_q) begin
        sat_cnt_q <= sat_cnt_d;
      end
      if (mode_err_set) begin
        mode_err_q <= 1'b1;
      end
    end
  end

  assign o_valid           = vld2_q;
  assign o_diff_flat       = diff_q;
  assign o_lane_mask       = mask2_q;
  assign o_length_mode_byp = mode2_q;
  assign o_sat_cnt         = sat_cnt_q;
  assign o_mode_err        = mode_err_q;

endmodule

// File: tb/tb_sub_max_stage.sv
// Self-checking bench for sub_max_stage: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_sub_max_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          en;
  logic          vld;
  logic          clr;
  logic [3:0]    mode;
  logic [1023:0] in_flat;
  logic [63:0]   mask;
  logic [15:0]   gmax;
  logic [15:0]   m64;
  logic [15:0]   m32 [2];
  logic [15:0]   m16 [4];

  logic          o_valid;
  logic [1023:0] o_diff_flat;
  logic [63:0]   o_lane_mask;
  logic [3:0]    o_length_mode_byp;
  logic [15:0]   o_sat_cnt;
  logic          o_mode_err;

  sub_max_stage dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_en             (en),
    .i_valid_max      (vld),
    .i_length_mode    (mode),
    .i_in_flat        (in_flat),
    .i_lane_mask      (mask),
    .i_global_max     (gmax),
    .i_max64_0        (m64),
    .i_max32_0        (m32[0]),
    .i_max32_1        (m32[1]),
    .i_max16_0        (m16[0]),
    .i_max16_1        (m16[1]),
    .i_max16_2        (m16[2]),
    .i_max16_3        (m16[3]),
    .i_clr_stats      (clr),
    .o_valid          (o_valid),
    .o_diff_flat      (o_diff_flat),
    .o_lane_mask      (o_lane_mask),
    .o_length_mode_byp(o_length_mode_byp),
    .o_sat_cnt        (o_sat_cnt),
    .o_mode_err       (o_mode_err)
  );

  typedef struct {
    bit                 vld;
    logic [63:0][15:0]  lane;
    logic [63:0]        mask;
    logic [3:0]         mode;
    int                 sat;
  } beat_t;

  beat_t pipe[$];
  beat_t cur;
  int    exp_sat;
  bit    exp_err;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic beat_t zero_beat();
    beat_t b;
    b.vld  = 1'b0;
    b.lane = '0;
    b.mask = '0;
    b.mode = '0;
    b.sat  = 0;
    return b;
  endfunction

  // Expected result of the beat currently on the inputs, straight from the
  // arithmetic rules: pick the row max, subtract in int, clamp.
  function automatic beat_t mk_beat();
    beat_t b;
    int x, m, d;
    logic [15:0] mx;
    b = zero_beat();
    b.vld  = vld;
    b.mask = mask;
    b.mode = mode;
    for (int k = 0; k < 64; k++) begin
      case (mode)
        4'd0:    mx = m16[k/16];
        4'd1:    mx = m32[k/32];
        4'd2:    mx = m64;
        default: mx = gmax;
      endcase
      x = $signed(in_flat[k*16 +: 16]);
      m = $signed(mx);
      d = x - m;
      if (!mask[k]) b.lane[k] = 16'h8000;
      else if (d < -32768) begin b.lane[k] = 16'h8000; b.sat++; end
      else if (d > 0) begin b.lane[k] = 16'h0000; b.sat++; end
      else b.lane[k] = d[15:0];
    end
    return b;
  endfunction

  task automatic model_reset();
    pipe.delete();
    pipe.push_back(zero_beat());
    cur     = zero_beat();
    exp_sat = 0;
    exp_err = 1'b0;
  endtask

  task automatic model_step();
    if (en) begin
      pipe.push_back(mk_beat());
      cur = pipe.pop_front();
    end
    if (clr) begin
      exp_sat = 0;
      exp_err = 1'b0;
    end else begin
      if (en && cur.vld) exp_sat = (exp_sat + cur.sat > 65535) ? 65535 : exp_sat + cur.sat;
      if (en && vld && mode > 4'd3) exp_err = 1'b1;
    end
  endtask

  task automatic check_outputs();
    chk("o_valid", 64'(o_valid), 64'(cur.vld));
    if (cur.vld) begin
      for (int k = 0; k < 64; k++)
        chk($sformatf("diff[%0d]", k), 64'(o_diff_flat[k*16 +: 16]), 64'(cur.lane[k]));
      chk("o_lane_mask", o_lane_mask, cur.mask);
      chk("o_length_mode_byp", 64'(o_length_mode_byp), 64'(cur.mode));
    end
    chk("o_sat_cnt", 64'(o_sat_cnt), 64'(exp_sat));
    chk("o_mode_err", 64'(o_mode_err), 64'(exp_err));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_step();
    #1;
    check_outputs();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(o_valid), 64'd0);
    chk({tag, "_diff_nz"}, 64'(o_diff_flat != '0), 64'd0);
    chk({tag, "_mask"}, o_lane_mask, 64'd0);
    chk({tag, "_mode"}, 64'(o_length_mode_byp), 64'd0);
    chk({tag, "_sat"}, 64'(o_sat_cnt), 64'd0);
    chk({tag, "_err"}, 64'(o_mode_err), 64'd0);
  endtask

  task automatic fill(input logic [15:0] v);
    for (int k = 0; k < 64; k++) in_flat[k*16 +: 16] = v;
  endtask

  task automatic rand_beat();
    mode = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15));
    mask = {$urandom, $urandom};
    gmax = 16'($urandom);
    m64  = 16'($urandom);
    for (int j = 0; j < 2; j++) m32[j] = 16'($urandom);
    for (int j = 0; j < 4; j++) m16[j] = 16'($urandom);
    for (int k = 0; k < 64; k++)
      in_flat[k*16 +: 16] = ($urandom_range(0, 3) == 0) ? m64 : 16'($urandom);
  endtask

  int nv;

  initial begin
    rst = 1'b0; en = 1'b1; vld = 1'b0; clr = 1'b0; mode = '0;
    in_flat = '0; mask = '0; gmax = '0; m64 = '0;
    m32[0] = '0; m32[1] = '0;
    for (int j = 0; j < 4; j++) m16[j] = '0;
    model_reset();
    #2;
    chk_all_zero("reset");
    repeat (2) cyc();
    rst = 1'b1;

    // Mode 2 ramp
    mode = 4'd2; mask = '1; m64 = 16'h00FC; vld = 1'b1;
    for (int k = 0; k < 64; k++) in_flat[k*16 +: 16] = 16'(k * 4);
    cyc();
    vld = 1'b0;
    chk("t1_early_valid", 64'(o_valid), 64'd0);
    cyc();
    chk("t1_valid", 64'(o_valid), 64'd1);
    chk("t1_lane0", 64'(o_diff_flat[15:0]), 64'h0000_0000_0000_FF04);
    chk("t1_lane63", 64'(o_diff_flat[1023:1008]), 64'd0);
    chk("t1_sat", 64'(o_sat_cnt), 64'd0);

    // Mode 0 then mode 2 on the same lanes
    mode = 4'd0; m16[0] = 16'd10; m16[1] = 16'd20; m16[2] = 16'd30; m16[3] = 16'd40;
    for (int k = 0; k < 64; k++) in_flat[k*16 +: 16] = 16'((k / 16 + 1) * 10);
    vld = 1'b1;
    cyc();
    mode = 4'd2; m64 = 16'd40;
    cyc();
    vld = 1'b0;
    chk("t2_m0_lane0", 64'(o_diff_flat[15:0]), 64'd0);
    chk("t2_m0_lane63", 64'(o_diff_flat[1023:1008]), 64'd0);
    cyc();
    chk("t2_m2_lane0", 64'(o_diff_flat[15:0]), 64'h0000_0000_0000_FFE2);
    chk("t2_m2_lane15", 64'(o_diff_flat[255:240]), 64'h0000_0000_0000_FFE2);
    chk("t2_m2_lane63", 64'(o_diff_flat[1023:1008]), 64'd0);

    // Saturation low, then clamp high
    mode = 4'd2; mask = '1; fill(16'h0000); in_flat[5*16 +: 16] = 16'h8000; m64 = 16'h7FFF; vld = 1'b1;
    cyc();
    fill(16'd40); in_flat[6*16 +: 16] = 16'd50; m64 = 16'd40;
    cyc();
    vld = 1'b0;
    chk("t3_lane5", 64'(o_diff_flat[95:80]), 64'h0000_0000_0000_8000);
    chk("t3_sat1", 64'(o_sat_cnt), 64'd1);
    cyc();
    chk("t3_lane6", 64'(o_diff_flat[111:96]), 64'd0);
    chk("t3_sat2", 64'(o_sat_cnt), 64'd2);

    // Reserved mode with half mask, then statistics clear
    mode = 4'd9; mask = 64'h0000_0000_FFFF_FFFF; gmax = 16'd100; fill(16'd100); vld = 1'b1;
    cyc();
    vld = 1'b0;
    chk("t4_err", 64'(o_mode_err), 64'd1);
    cyc();
    chk("t4_lane0", 64'(o_diff_flat[15:0]), 64'd0);
    chk("t4_lane32", 64'(o_diff_flat[527:512]), 64'h0000_0000_0000_8000);
    chk("t4_lane63", 64'(o_diff_flat[1023:1008]), 64'h0000_0000_0000_8000);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("t4_clr_sat", 64'(o_sat_cnt), 64'd0);
    chk("t4_clr_err", 64'(o_mode_err), 64'd0);

    // Stall between B and C
    nv = 0;
    rand_beat(); vld = 1'b1; cyc(); nv += int'(o_valid);
    rand_beat(); cyc(); nv += int'(o_valid);
    rand_beat(); en = 1'b0;
    repeat (3) cyc();
    en = 1'b1;
    cyc(); nv += int'(o_valid);
    vld = 1'b0;
    repeat (3) begin cyc(); nv += int'(o_valid); end
    chk("t5_beats_out", 64'(nv), 64'd3);

    // Asynchronous reset with two beats in flight
    rand_beat(); vld = 1'b1; cyc();
    rand_beat(); cyc();
    #3 rst = 1'b0;
    #1;
    model_reset();
    chk_all_zero("arst");
    vld = 1'b0;
    cyc();
    rst = 1'b1;
    repeat (2) cyc();
    rand_beat(); vld = 1'b1; cyc();
    vld = 1'b0;
    cyc();
    chk("t6_new_valid", 64'(o_valid), 64'd1);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      rand_beat();
      en  = ($urandom_range(0, 9) != 0);
      vld = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 19) == 0);
      cyc();
    end
    clr = 1'b0; en = 1'b1;

    // Drive the counter into saturation: 64 saturated lanes per beat
    mode = 4'd2; mask = '1; fill(16'h8000); m64 = 16'h7FFF; vld = 1'b1;
    repeat (1030) cyc();
    chk("satcnt_max", 64'(o_sat_cnt), 64'h0000_0000_0000_FFFF);
    vld = 1'b0; clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("satcnt_clr", 64'(o_sat_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
